// File: rtl/mem_ctrl_np_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl_np_if
//  Purpose  : Request/grant/read-return bundle between requesting engines
//             and the N-port memory controller.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_ctrl_np_if #(
   parameter int NUM_PORTS = 2,
   parameter int D_W       = 8,
   parameter int A_W       = 6
);
   logic [NUM_PORTS-1:0]     input_req;
   logic [NUM_PORTS-1:0]     input_we;
   logic [NUM_PORTS*A_W-1:0] input_Add;
   logic [NUM_PORTS*D_W-1:0] input_Din;
   logic [1:0]               input_inj;
   logic [NUM_PORTS-1:0]     output_gnt;
   logic [NUM_PORTS*D_W-1:0] output_Dout;
   logic [NUM_PORTS-1:0]     output_valid;
   logic [NUM_PORTS-1:0]     output_err;
   logic [NUM_PORTS-1:0]     output_corr;

   // Requesting side
   modport master (
      output input_req, input_we, input_Add, input_Din, input_inj,
      input  output_gnt, output_Dout, output_valid, output_err, output_corr
   );

   // Controller side
   modport slave (
      input  input_req, input_we, input_Add, input_Din, input_inj,
      output output_gnt, output_Dout, output_valid, output_err, output_corr
   );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl_np.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl_np
//  Purpose  : N-port round-robin memory controller with an integrated
//             protected RAM, a shared in-order latency pipeline, per-port
//             read-return flags and test-only codeword error injection.
//  Options  : MEM_ECC_EN defined   -> Hamming SECDED codeword
//             MEM_ECC_EN undefined -> single even-parity bit
//  Revision : 1.0  initial release
// ============================================================================
module mem_ctrl_np #(
   parameter int NUM_PORTS = 2,
   parameter int D_W       = 8,
   parameter int A_W       = 6,
   parameter int DEPTH     = 64,
   parameter int WL        = 3,
   parameter int RL        = 3
) (
   input  logic         input_clk,
   input  logic         input_rst,
   mem_ctrl_np_if.slave bus
);

   localparam int c_PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int c_NREG = (RL > 1) ? RL - 1 : 1;

   // Catch illegal configurations at elaboration
   if (WL < 1 || RL < WL || NUM_PORTS < 1 || NUM_PORTS > 8 || DEPTH > (1 << A_W))
   begin : g_badConfig
      $error("mem_ctrl_np: illegal parameter combination");
   end

`ifdef MEM_ECC_EN
   // Smallest Hamming check-bit count covering D_W data bits
   function automatic int hamParity(input int dw);
      int p;
      p = 0;
      while ((1 << p) < dw + p + 1) p++;
      return p;
   endfunction

   localparam int c_P  = hamParity(D_W);
   localparam int c_CW = D_W + c_P + 1;

   // Bit 0 is overall parity; bits 1..c_CW-1 are Hamming positions with
   // check bits at powers of two and data bits filling the rest in order.
   function automatic logic [c_CW-1:0] encode(input logic [D_W-1:0] data);
      logic [c_CW-1:0] cw;
      logic [D_W-1:0]  rem;
      cw  = '0;
      rem = data;
      for (int pos = 1; pos < c_CW; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            cw[pos] = rem[0];
            rem     = rem >> 1;
         end
      end
      for (int i = 0; i < c_P; i++) begin
         for (int pos = 1; pos < c_CW; pos++) begin
            if (((pos >> i) & 1) == 1 && pos != (1 << i)) begin
               cw[1 << i] = cw[1 << i] ^ cw[pos];
            end
         end
      end
      cw[0] = ^cw[c_CW-1:1];
      return cw;
   endfunction

   // Returns {err, corr, data}
   function automatic logic [D_W+1:0] decode(input logic [c_CW-1:0] cwIn);
      logic [c_CW-1:0] cw;
      logic [D_W-1:0]  data;
      logic            err;
      logic            corr;
      int              syn;
      cw   = cwIn;
      data = '0;
      err  = 1'b0;
      corr = 1'b0;
      syn  = 0;
      for (int pos = 1; pos < c_CW; pos++) begin
         if (cwIn[pos]) syn = syn ^ pos;
      end
      if (^cwIn) begin
         // Odd overall parity: a single flip, syndrome 0 means bit 0 itself
         if (syn < c_CW) begin
            cw   = cwIn ^ (c_CW'(1) << syn);
            corr = 1'b1;
         end else begin
            err = 1'b1;
         end
      end else if (syn != 0) begin
         err = 1'b1;
      end
      for (int pos = 1; pos < c_CW; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            data = (data >> 1) | (D_W'(cw[pos]) << (D_W - 1));
         end
      end
      return {err, corr, data};
   endfunction
`else
   localparam int c_CW = D_W + 1;

   function automatic logic [c_CW-1:0] encode(input logic [D_W-1:0] data);
      return {^data, data};
   endfunction

   // Returns {err, corr, data}; parity can only detect, never correct
   function automatic logic [D_W+1:0] decode(input logic [c_CW-1:0] cwIn);
      return {^cwIn, 1'b0, cwIn[D_W-1:0]};
   endfunction
`endif

   typedef struct packed {
      logic            vld;
      logic [c_PW-1:0] port;
      logic            we;
      logic [A_W-1:0]  addr;
      logic [c_CW-1:0] cw;
   } op_t;

   logic [c_PW-1:0]      r_rrPtr;
   logic [NUM_PORTS-1:0] w_gnt;
   logic [c_PW-1:0]      w_gntIdx;
   logic                 w_gntAny;
   logic [c_CW-1:0]      w_injMask;
   op_t                  w_acc;
   op_t                  r_pipe [c_NREG];

   logic                 w_wrVld;
   logic [A_W-1:0]       w_wrAddr;
   logic [c_CW-1:0]      w_wrCw;
   logic                 w_wrInRange;

   logic                 w_rdVld;
   logic [c_PW-1:0]      w_rdPort;
   logic [A_W-1:0]       w_rdAddr;
   logic                 w_rdInRange;
   logic [c_CW-1:0]      w_rdWord;
   logic [D_W+1:0]       w_rdDec;

   logic [c_CW-1:0]      r_mem  [DEPTH];
   logic [D_W-1:0]       r_dout [NUM_PORTS];
   logic [NUM_PORTS-1:0] r_valid;
   logic [NUM_PORTS-1:0] r_err;
   logic [NUM_PORTS-1:0] r_corr;

   // Round-robin search: first requester at or after the pointer wins
   always_comb begin
      int idx;
      idx      = 0;
      w_gnt    = '0;
      w_gntIdx = '0;
      w_gntAny = 1'b0;
      if (!input_rst) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(r_rrPtr) + i) % NUM_PORTS;
            if (!w_gntAny && bus.input_req[idx]) begin
               w_gnt[idx] = 1'b1;
               w_gntIdx   = c_PW'(idx);
               w_gntAny   = 1'b1;
            end
         end
      end
   end

   // Pointer moves past the winner; holds when nothing is granted
   always_ff @(posedge input_clk) begin
      if (input_rst) begin
         r_rrPtr <= '0;
      end else if (w_gntAny) begin
         r_rrPtr <= (w_gntIdx == c_PW'(NUM_PORTS - 1)) ? '0 : w_gntIdx + 1'b1;
      end
   end

   // Injection pattern on the accepted write's codeword; 3 means none
   always_comb begin
      w_injMask = '0;
      case (bus.input_inj)
         2'd1:    w_injMask = c_CW'(1);
         2'd2:    w_injMask = c_CW'(3);
         default: w_injMask = '0;
      endcase
   end

   // Capture the accepted op; the codeword is built here, not at commit
   always_comb begin
      w_acc      = '0;
      w_acc.vld  = w_gntAny;
      w_acc.port = w_gntIdx;
      w_acc.we   = bus.input_we[w_gntIdx];
      w_acc.addr = bus.input_Add[int'(w_gntIdx)*A_W +: A_W];
      w_acc.cw   = encode(bus.input_Din[int'(w_gntIdx)*D_W +: D_W]) ^ w_injMask;
   end

   // Shared latency pipeline; reset discards everything in flight
   always_ff @(posedge input_clk) begin
      if (input_rst) begin
         for (int k = 0; k < c_NREG; k++) r_pipe[k].vld <= 1'b0;
      end else begin
         r_pipe[0] <= w_acc;
         for (int k = 1; k < c_NREG; k++) r_pipe[k] <= r_pipe[k-1];
      end
   end

   // Write commits from stage WL-1, read samples at stage RL-1
   if (WL == 1) begin : g_wrStage0
      assign w_wrVld  = w_acc.vld & w_acc.we;
      assign w_wrAddr = w_acc.addr;
      assign w_wrCw   = w_acc.cw;
   end else begin : g_wrStageN
      assign w_wrVld  = r_pipe[WL-2].vld & r_pipe[WL-2].we;
      assign w_wrAddr = r_pipe[WL-2].addr;
      assign w_wrCw   = r_pipe[WL-2].cw;
   end

   if (RL == 1) begin : g_rdStage0
      assign w_rdVld  = w_acc.vld & ~w_acc.we;
      assign w_rdPort = w_acc.port;
      assign w_rdAddr = w_acc.addr;
   end else begin : g_rdStageN
      assign w_rdVld  = r_pipe[RL-2].vld & ~r_pipe[RL-2].we;
      assign w_rdPort = r_pipe[RL-2].port;
      assign w_rdAddr = r_pipe[RL-2].addr;
   end

   assign w_wrInRange = int'(w_wrAddr) < DEPTH;
   assign w_rdInRange = int'(w_rdAddr) < DEPTH;
   assign w_rdWord    = w_rdInRange ? r_mem[w_rdAddr] : '0;
   assign w_rdDec     = decode(w_rdWord);

   // Array update; out-of-range writes are dropped, contents survive reset
   always_ff @(posedge input_clk) begin
      if (!input_rst && w_wrVld && w_wrInRange) begin
         r_mem[w_wrAddr] <= w_wrCw;
      end
   end

   // Per-port read return; Dout holds between pulses, other ports untouched
   always_ff @(posedge input_clk) begin
      if (input_rst) begin
         r_valid <= '0;
         r_err   <= '0;
         r_corr  <= '0;
         for (int p = 0; p < NUM_PORTS; p++) r_dout[p] <= '0;
      end else begin
         r_valid <= '0;
         r_err   <= '0;
         r_corr  <= '0;
         if (w_rdVld) begin
            r_valid[w_rdPort] <= 1'b1;
            if (w_rdInRange) begin
               r_err[w_rdPort]  <= w_rdDec[D_W+1];
               r_corr[w_rdPort] <= w_rdDec[D_W];
               r_dout[w_rdPort] <= w_rdDec[D_W-1:0];
            end else begin
               r_err[w_rdPort]  <= 1'b1;
               r_dout[w_rdPort] <= '0;
            end
         end
      end
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dout
      assign bus.output_Dout[p*D_W +: D_W] = r_dout[p];
   end

   assign bus.output_gnt   = w_gnt;
   assign bus.output_valid = r_valid;
   assign bus.output_err   = r_err;
   assign bus.output_corr  = r_corr;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl_np.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_ctrl_np
//  Purpose  : Self-checking bench for mem_ctrl_np with a transaction-level
//             reference model (ordered op queue + plain memory array).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_ctrl_np;
   localparam int NP   = 2;
   localparam int DW   = 8;
   localparam int AW   = 6;
   localparam int DEP  = 48;
   localparam int WLAT = 3;
   localparam int RLAT = 3;
   localparam int OW   = 4*NP + NP*DW;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_ctrl_np_if #(.NUM_PORTS(NP), .D_W(DW), .A_W(AW)) bus ();

   mem_ctrl_np #(
      .NUM_PORTS(NP), .D_W(DW), .A_W(AW), .DEPTH(DEP), .WL(WLAT), .RL(RLAT)
   ) dut (
      .input_clk(clk),
      .input_rst(rst),
      .bus(bus.slave)
   );

   typedef struct {
      int acc;
      int port;
      bit we;
      int addr;
      int data;
      int inj;
   } op_t;

   op_t           q[$];
   int            mPtr = 0;
   int            mCyc = 0;
   int            mData [DEP];
   int            mInj  [DEP];
   logic [DW-1:0] mDout [NP];
   logic [NP-1:0] mValid = '0;
   logic [NP-1:0] mErr   = '0;
   logic [NP-1:0] mCorr  = '0;
   int            lastGrant = -1;
   int            nPass = 0;
   int            nChecks = 0;

   // Read result from the stored value and the injection it was written with
   function automatic void expRead(input int a, output logic [DW-1:0] d,
                                   output logic er, output logic co);
      d = '0; er = 1'b0; co = 1'b0;
      if (a >= DEP) begin
         er = 1'b1;
      end else begin
         d = DW'(mData[a]);
`ifdef MEM_ECC_EN
         if (mInj[a] == 1) co = 1'b1;
         else if (mInj[a] == 2) er = 1'b1;
`else
         if (mInj[a] == 1) begin
            d  = d ^ DW'(1);
            er = 1'b1;
         end else if (mInj[a] == 2) begin
            d = d ^ DW'(3);
         end
`endif
      end
   endfunction

   task automatic setReq(input int p, input bit r, input bit w, input int a, input int d);
      bus.input_req[p]           = r;
      bus.input_we[p]            = w;
      bus.input_Add[p*AW +: AW]  = AW'(a);
      bus.input_Din[p*DW +: DW]  = DW'(d);
   endtask

   task automatic idle();
      bus.input_req = '0;
      bus.input_inj = 2'd0;
   endtask

   // One clock: sample DUT vs model mid-cycle, then advance the model
   task automatic tick(output logic [OW-1:0] o, output logic [OW-1:0] e);
      logic [NP-1:0]    eg, nv, ne, nc;
      logic [NP*DW-1:0] ed;
      logic [DW-1:0]    d;
      logic             er, co;
      op_t              op;
      int               gi;
      @(negedge clk);
      gi = -1;
      if (!rst) begin
         for (int i = 0; i < NP; i++) begin
            if (gi < 0 && bus.input_req[(mPtr + i) % NP]) gi = (mPtr + i) % NP;
         end
      end
      eg = '0;
      if (gi >= 0) eg[gi] = 1'b1;
      for (int p = 0; p < NP; p++) ed[p*DW +: DW] = mDout[p];
      e = {eg, mValid, ed, mErr & mValid, mCorr & mValid};
      o = {bus.output_gnt, bus.output_valid, bus.output_Dout,
           bus.output_err & bus.output_valid, bus.output_corr & bus.output_valid};
      @(posedge clk);
      if (rst) begin
         q.delete();
         mPtr = 0; mValid = '0; mErr = '0; mCorr = '0;
         for (int p = 0; p < NP; p++) mDout[p] = '0;
      end else begin
         if (gi >= 0) begin
            op.acc  = mCyc;
            op.port = gi;
            op.we   = bus.input_we[gi];
            op.addr = int'(bus.input_Add[gi*AW +: AW]);
            op.data = int'(bus.input_Din[gi*DW +: DW]);
            op.inj  = (bus.input_inj == 2'd3) ? 0 : int'(bus.input_inj);
            q.push_back(op);
            mPtr = (gi + 1) % NP;
         end
         nv = '0; ne = '0; nc = '0;
         for (int k = q.size() - 1; k >= 0; k--) begin
            if (q[k].we && q[k].acc + WLAT - 1 == mCyc) begin
               if (q[k].addr < DEP) begin
                  mData[q[k].addr] = q[k].data;
                  mInj[q[k].addr]  = q[k].inj;
               end
               q.delete(k);
            end else if (!q[k].we && q[k].acc + RLAT - 1 == mCyc) begin
               expRead(q[k].addr, d, er, co);
               mDout[q[k].port] = d;
               nv[q[k].port] = 1'b1;
               ne[q[k].port] = er;
               nc[q[k].port] = co;
               q.delete(k);
            end
         end
         mValid = nv; mErr = ne; mCorr = nc;
      end
      lastGrant = gi;
      mCyc++;
      #1;
   endtask

   task automatic test_reset();
      logic [OW-1:0] o, e;
      rst = 1'b1;
      setReq(0, 1, 0, 3, 0);
      setReq(1, 1, 1, 4, 8'h77);
      for (int i = 0; i < 3; i++) begin
         tick(o, e);
         nChecks++;
         if (o !== e) $display("FAIL reset cyc%0d got=%h exp=%h", mCyc - 1, o, e);
         else nPass++;
      end
      nChecks++;
      if ({bus.output_valid, bus.output_Dout, bus.output_err, bus.output_corr} !== '0)
         $display("FAIL reset_state got=%h exp=0", {bus.output_valid, bus.output_Dout});
      else nPass++;
      rst = 1'b0;
      idle();
   endtask

   task automatic test_fill();
      logic [OW-1:0] o, e;
      for (int i = 0; i < DEP + 4; i++) begin
         if (i < DEP) setReq(0, 1, 1, i, $urandom_range(0, 255));
         else idle();
         tick(o, e);
         nChecks++;
         if (o !== e) $display("FAIL fill cyc%0d got=%h exp=%h", mCyc - 1, o, e);
         else nPass++;
      end
   endtask

   task automatic test_basic();
      logic [OW-1:0] o, e;
      for (int i = 0; i < 6; i++) begin
         if (i == 0) setReq(0, 1, 1, 5, 8'hA5);
         else if (i == 1) setReq(0, 1, 0, 5, 0);
         else idle();
         tick(o, e);
         nChecks++;
         if (o !== e) $display("FAIL basic cyc%0d got=%h exp=%h", mCyc - 1, o, e);
         else nPass++;
         if (i == 3) begin
            nChecks++;
            if ({bus.output_valid[0], bus.output_Dout[7:0], bus.output_err[0]} !== {1'b1, 8'hA5, 1'b0})
               $display("FAIL basic_read got v/d/e=%b/%h/%b exp=1/a5/0",
                        bus.output_valid[0], bus.output_Dout[7:0], bus.output_err[0]);
            else nPass++;
         end
      end
   endtask

   task automatic test_rr();
      logic [OW-1:0] o, e;
      logic [NP-1:0] pat [4];
      pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b10;
      rst = 1'b1;
      tick(o, e);
      nChecks++;
      if (o !== e) $display("FAIL rr_rst got=%h exp=%h", o, e);
      else nPass++;
      rst = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i < 4) begin
            setReq(0, 1, 0, 1, 0);
            setReq(1, 1, 0, 2, 0);
         end else idle();
         tick(o, e);
         nChecks++;
         if (o !== e) $display("FAIL rr cyc%0d got=%h exp=%h", mCyc - 1, o, e);
         else nPass++;
         if (i < 4) begin
            nChecks++;
            if (o[OW-1 -: NP] !== pat[i])
               $display("FAIL rr_gnt%0d got=%b exp=%b", i, o[OW-1 -: NP], pat[i]);
            else nPass++;
         end
      end
   endtask

   task automatic test_inj_single();
      logic [OW-1:0] o, e;
      logic [DW+1:0] want;
`ifdef MEM_ECC_EN
      want = {8'hFF, 1'b0, 1'b1};
`else
      want = {8'hFE, 1'b1, 1'b0};
`endif
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin setReq(1, 1, 1, DEP - 1, 8'hFF); bus.input_inj = 2'd1; end
         else if (i == 1) begin setReq(1, 1, 0, DEP - 1, 0); bus.input_inj = 2'd0; end
         else idle();
         tick(o, e);
         nChecks++;
         if (o !== e) $display("FAIL inj1 cyc%0d got=%h exp=%h", mCyc - 1, o, e);
         else nPass++;
         if (i == 3) begin
            nChecks++;
            if ({bus.output_valid[1], bus.output_Dout[15:8], bus.output_err[1], bus.output_corr[1]} !== {1'b1, want})
               $display("FAIL inj1_read got=%h exp=%h",
                        {bus.output_Dout[15:8], bus.output_err[1], bus.output_corr[1]}, want);
            else nPass++;
         end
      end
   endtask

   task automatic test_inj_double();
      logic [OW-1:0] o, e;
      logic [1:0] want;
`ifdef MEM_ECC_EN
      want = 2'b10;
`else
      want = 2'b00;
`endif
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin setReq(0, 1, 1, 10, 8'h3C); bus.input_inj = 2'd2; end
         else if (i == 1) begin setReq(0, 1, 0, 10, 0); bus.input_inj = 2'd0; end
         else idle();
         tick(o, e);
         nChecks++;
         if (o !== e) $display("FAIL inj2 cyc%0d got=%h exp=%h", mCyc - 1, o, e);
         else nPass++;
         if (i == 3) begin
            nChecks++;
            if ({bus.output_err[0], bus.output_corr[0]} !== want)
               $display("FAIL inj2_flags got=%b exp=%b", {bus.output_err[0], bus.output_corr[0]}, want);
            else nPass++;
`ifndef MEM_ECC_EN
            nChecks++;
            if (bus.output_Dout[7:0] !== 8'h3F)
               $display("FAIL inj2_data got=%h exp=3f", bus.output_Dout[7:0]);
            else nPass++;
`endif
         end
      end
   endtask

   task automatic test_out_of_range();
      logic [OW-1:0] o, e;
      for (int i = 0; i < 8; i++) begin
         case (i)
            0: setReq(0, 1, 1, 50, 8'h11);
            1: setReq(0, 1, 0, 50, 0);
            2: setReq(0, 1, 0, DEP, 0);
            3: setReq(0, 1, 0, 50 - DEP, 0);
            default: idle();
         endcase
         tick(o, e);
         nChecks++;
         if (o !== e) $display("FAIL oor cyc%0d got=%h exp=%h", mCyc - 1, o, e);
         else nPass++;
         if (i == 3) begin
            nChecks++;
            if ({bus.output_valid[0], bus.output_Dout[7:0], bus.output_err[0]} !== {1'b1, 8'h00, 1'b1})
               $display("FAIL oor_read got v/d/e=%b/%h/%b exp=1/00/1",
                        bus.output_valid[0], bus.output_Dout[7:0], bus.output_err[0]);
            else nPass++;
         end
      end
   endtask

   task automatic test_reset_flush();
      logic [OW-1:0] o, e;
      for (int i = 0; i < 14; i++) begin
         rst = (i == 5);
         case (i)
            0: setReq(0, 1, 1, 7, 8'h12);
            4: setReq(0, 1, 1, 7, 8'h55);
            9: setReq(0, 1, 0, 7, 0);
            default: idle();
         endcase
         tick(o, e);
         nChecks++;
         if (o !== e) $display("FAIL flush cyc%0d got=%h exp=%h", mCyc - 1, o, e);
         else nPass++;
         if (i == 11) begin
            nChecks++;
            if ({bus.output_valid[0], bus.output_Dout[7:0]} !== {1'b1, 8'h12})
               $display("FAIL flush_read got v/d=%b/%h exp=1/12", bus.output_valid[0], bus.output_Dout[7:0]);
            else nPass++;
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [OW-1:0] o, e;
      int a;
      a = 0;
      for (int i = 0; i < 44; i++) begin
         if (i < 40) begin
            if (i % 4 == 0) a = $urandom_range(0, DEP - 1);
            setReq(0, 1, (i % 4) < 2, a, $urandom_range(0, 255));
         end else idle();
         tick(o, e);
         nChecks++;
         if (o !== e) $display("FAIL b2b cyc%0d got=%h exp=%h", mCyc - 1, o, e);
         else nPass++;
      end
   endtask

   task automatic test_random();
      logic [OW-1:0] o, e;
      bit pend [NP];
      for (int p = 0; p < NP; p++) pend[p] = 1'b0;
      for (int c = 0; c < 306; c++) begin
         if (c < 300) begin
            for (int p = 0; p < NP; p++) begin
               if (!pend[p]) begin
                  if ($urandom_range(0, 9) < 6) begin
                     pend[p] = 1'b1;
                     setReq(p, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom_range(0, 255));
                  end else begin
                     bus.input_req[p] = 1'b0;
                  end
               end
            end
            bus.input_inj = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         end else idle();
         tick(o, e);
         nChecks++;
         if (o !== e) $display("FAIL random cyc%0d got=%h exp=%h", mCyc - 1, o, e);
         else nPass++;
         if (lastGrant >= 0) pend[lastGrant] = 1'b0;
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.input_req = '0;
      bus.input_we  = '0;
      bus.input_Add = '0;
      bus.input_Din = '0;
      bus.input_inj = 2'd0;
      for (int p = 0; p < NP; p++) mDout[p] = '0;
      for (int a = 0; a < DEP; a++) begin
         mData[a] = 0;
         mInj[a]  = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_fill();
      test_basic();
      test_rr();
      test_inj_single();
      test_inj_double();
      test_out_of_range();
      test_reset_flush();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule
`default_nettype wire
